// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the MEM-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int WAIT_CNT_W = 4;

  // Word number of a byte address; callers keep only the low index bits.
  function automatic logic [31:0] addr_to_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || (addr >= 32'(depth_words * 4));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM with synchronous write and registered read; drop-in slot for a vendor BRAM.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request per handshake, programmable wait
// states, single-cycle response pulse and a pipeline stall while waiting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  load_hit;
  logic                  accept;
  logic                  req_bad;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           ram_rdata;

  assign req_ready  = (state == IDLE) || (state == RESP);
  assign resp_valid = (state == RESP);
  assign stall      = (state == WAIT);
  assign accept     = req_valid && req_ready;
  assign req_bad    = addr_err(req_addr, DEPTH_WORDS);
  assign idx        = IDX_W'(addr_to_word(req_addr));

  // The RAM output register holds the load data; it only changes on a good
  // load, so masking it with load_hit gives the held response data.
  assign resp_rdata = load_hit ? ram_rdata : 32'h0;

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (accept && req_we && !req_bad),
    .widx  (idx),
    .wdata (req_wdata),
    .re    (accept && !req_we && !req_bad),
    .ridx  (idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      load_hit <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            resp_err <= req_bad;
            load_hit <= !req_we && !req_bad;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end else if (state == RESP) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= RESP;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked each
// cycle against a transaction-level model, plus hand-computed directed checks.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        stall     [2];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      dmem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (gi == 0 ? 2 : 0)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[gi]),
        .req_ready  (req_ready[gi]),
        .req_we     (req_we[gi]),
        .req_addr   (req_addr[gi]),
        .req_wdata  (req_wdata[gi]),
        .resp_valid (resp_valid[gi]),
        .resp_rdata (resp_rdata[gi]),
        .resp_err   (resp_err[gi]),
        .stall      (stall[gi])
      );
    end
  endgenerate

  int checks = 0;
  int passed = 0;

  // Model: cycle index, edge of the most recent accept, expected response, memory image.
  int          cyc = 0;
  int          acc_cyc [2] = '{-1, -1};
  bit          acc_flag[2];
  logic [31:0] exp_rdata[2];
  logic        exp_err [2];
  logic [31:0] mem_m [2][256];
  logic [31:0] vlog[$];

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Cycle c is the interval following rising edge c.
  function automatic bit m_stall(input int i, input int c);
    return acc_cyc[i] >= 0 && c >= acc_cyc[i] && c < acc_cyc[i] + wc(i);
  endfunction

  function automatic bit m_valid(input int i, input int c);
    return acc_cyc[i] >= 0 && c == acc_cyc[i] + wc(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(posedge clk) begin
    int   c;
    logic bad;
    int   w;
    c   = cyc;
    cyc = c + 1;
    for (int i = 0; i < 2; i++) begin
      acc_flag[i] = 1'b0;
      if (rst) begin
        acc_cyc[i]   = -1;
        exp_rdata[i] = 32'h0;
        exp_err[i]   = 1'b0;
      end else if (req_valid[i] && !m_stall(i, c)) begin
        bad = (req_addr[i][1:0] != 2'b00) || (req_addr[i] >= 32'd1024);
        w   = int'(req_addr[i][9:2]);
        if (req_we[i] && !bad) mem_m[i][w] = req_wdata[i];
        exp_rdata[i] = (!req_we[i] && !bad) ? mem_m[i][w] : 32'h0;
        exp_err[i]   = bad;
        acc_cyc[i]   = cyc;
        acc_flag[i]  = 1'b1;
        $display("[cyc %0d] dut%0d %s addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d",
                 cyc, i, req_we[i] ? "store" : "load ", req_addr[i], req_wdata[i],
                 exp_rdata[i], exp_err[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
        chk($sformatf("rst_valid%0d", i), 32'(resp_valid[i]), 32'd0);
        chk($sformatf("rst_stall%0d", i), 32'(stall[i]), 32'd0);
        chk($sformatf("rst_rdata%0d", i), resp_rdata[i], 32'h0);
        chk($sformatf("rst_err%0d", i), 32'(resp_err[i]), 32'd0);
      end else begin
        chk($sformatf("ready%0d", i), 32'(req_ready[i]), 32'(!m_stall(i, cyc)));
        chk($sformatf("stall%0d", i), 32'(stall[i]), 32'(m_stall(i, cyc)));
        chk($sformatf("valid%0d", i), 32'(resp_valid[i]), 32'(m_valid(i, cyc)));
        if (m_valid(i, cyc)) begin
          chk($sformatf("rdata%0d", i), resp_rdata[i], exp_rdata[i]);
          chk($sformatf("err%0d", i), 32'(resp_err[i]), 32'(exp_err[i]));
        end
      end
      if (i == 1 && resp_valid[1]) vlog.push_back(resp_rdata[1]);
    end
  end

  // Present a request at the next falling edge and hold it until accepted;
  // returns just after the accept edge with req_valid dropped.
  task automatic req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag[i] && n < 50);
    if (!acc_flag[i]) begin
      checks++;
      $display("FAIL req_accept_timeout: dut%0d addr 0x%08h never accepted", i, a);
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, output int n, output logic [31:0] d,
                           output logic e, output int st);
    bit seen;
    n = 0; st = 0; d = 32'h0; e = 1'b0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (stall[i]) st++;
      if (resp_valid[i]) begin
        d = resp_rdata[i];
        e = resp_err[i];
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      $display("FAIL resp_timeout: dut%0d got no response within 20 cycles, expected one", i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected to have finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, st, seen;
    logic [31:0] d;
    logic        e;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Store then load with two wait states.
    req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    wait_resp(0, n, d, e, st);
    chk("st_latency", 32'(n), 32'd3);
    chk("st_stall_cycles", 32'(st), 32'd2);
    chk("st_rdata", d, 32'h0);
    chk("st_err", 32'(e), 32'd0);
    req(0, 1'b0, 32'h10, 32'h0);
    wait_resp(0, n, d, e, st);
    chk("ld_rdata", d, 32'hDEADBEEF);
    chk("ld_latency", 32'(n), 32'd3);
    chk("ld_stall_cycles", 32'(st), 32'd2);
    chk("model_pin_mem", mem_m[0][4], 32'hDEADBEEF);

    // Back-to-back loads with no wait states.
    req(1, 1'b1, 32'h0, 32'd1);
    req(1, 1'b1, 32'h4, 32'd2);
    req(1, 1'b1, 32'h8, 32'd3);
    repeat (2) @(negedge clk);
    #1;
    vlog.delete();
    req(1, 1'b0, 32'h0, 32'h0);
    req(1, 1'b0, 32'h4, 32'h0);
    req(1, 1'b0, 32'h8, 32'h0);
    chk("b2b_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b_count", 32'(vlog.size()), 32'd3);
    if (vlog.size() == 3) begin
      chk("b2b_data0", vlog[0], 32'd1);
      chk("b2b_data1", vlog[1], 32'd2);
      chk("b2b_data2", vlog[2], 32'd3);
    end

    // Misaligned and out-of-range accesses.
    req(1, 1'b0, 32'h13, 32'h0);
    wait_resp(1, n, d, e, st);
    chk("mis_ld_err", 32'(e), 32'd1);
    chk("mis_ld_rdata", d, 32'h0);
    req(1, 1'b0, 32'h400, 32'h0);
    wait_resp(1, n, d, e, st);
    chk("oor_ld_err", 32'(e), 32'd1);
    chk("oor_ld_rdata", d, 32'h0);
    req(1, 1'b1, 32'h402, 32'hBAD0BAD0);
    wait_resp(1, n, d, e, st);
    chk("oor_st_err", 32'(e), 32'd1);
    chk("oor_st_rdata", d, 32'h0);
    req(1, 1'b1, 32'h400, 32'hBAD1BAD1);
    wait_resp(1, n, d, e, st);
    chk("oor_st_aligned_err", 32'(e), 32'd1);
    req(1, 1'b0, 32'h0, 32'h0);
    wait_resp(1, n, d, e, st);
    chk("alias_unchanged", d, 32'd1);
    chk("alias_err", 32'(e), 32'd0);

    // Reset during the wait of a load: no response, immediate ready.
    req(0, 1'b0, 32'h10, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_stall", 32'(stall[0]), 32'd0);
    chk("async_ready", 32'(req_ready[0]), 32'd1);
    chk("async_valid", 32'(resp_valid[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid[0]) seen++;
    end
    chk("discarded_load", 32'(seen), 32'd0);

    // Reset during the wait of a store: the write stays committed.
    req(0, 1'b1, 32'h20, 32'h55);
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req(0, 1'b0, 32'h20, 32'h0);
    wait_resp(0, n, d, e, st);
    chk("store_survives_rst", d, 32'h55);

    // Address wiggling while stalled: only the accept-edge address counts.
    req(0, 1'b1, 32'h24, 32'h1111);
    wait_resp(0, n, d, e, st);
    req(0, 1'b1, 32'h28, 32'h2222);
    wait_resp(0, n, d, e, st);
    req(0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h24;
    @(posedge clk);
    #1;
    chk("wait_ignored1", 32'(acc_flag[0]), 32'd0);
    @(negedge clk);
    req_addr[0] = 32'h28;
    @(posedge clk);
    #1;
    chk("wait_ignored2", 32'(acc_flag[0]), 32'd0);
    @(negedge clk);
    req_addr[0] = 32'h20;
    @(posedge clk);
    #1;
    chk("accept_after_resp", 32'(acc_flag[0]), 32'd1);
    req_valid[0] = 1'b0;
    wait_resp(0, n, d, e, st);
    chk("held_addr_data", d, 32'h55);
    chk("held_addr_latency", 32'(n), 32'd3);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
